// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared CPU definitions: fetch FSM states, reset vector, branch op codes
package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    localparam int unsigned RESET_VECTOR_DEFAULT = 0;

    typedef enum logic [2:0] {
        BR_EQ   = 3'd0,
        BR_NE   = 3'd1,
        BR_LT   = 3'd2,
        BR_GE   = 3'd3,
        BR_LTU  = 3'd4,
        BR_GEU  = 3'd5,
        BR_JAL  = 3'd6,
        BR_NONE = 3'd7
    } branch_op_e;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - fetch control bundle between pipeline control and the PC unit
interface fetch_pc_unit_if #(
    parameter int PC_WIDTH  = 16,
    parameter int CNT_WIDTH = 16
);
    logic                 iBranchCmd;
    logic [PC_WIDTH-1:0]  iBranchTarget;
    logic                 iStall;
    logic                 iHalt;
    logic                 iImemReady;
    logic [PC_WIDTH-1:0]  oPc;
    logic [PC_WIDTH-1:0]  oPcPlus1;
    logic                 oFetchValid;
    logic                 oFlush;
    logic                 oHalted;
    logic [CNT_WIDTH-1:0] oBranchCount;

    modport master (
        output iBranchCmd, iBranchTarget, iStall, iHalt, iImemReady,
        input  oPc, oPcPlus1, oFetchValid, oFlush, oHalted, oBranchCount
    );

    modport slave (
        input  iBranchCmd, iBranchTarget, iStall, iHalt, iImemReady,
        output oPc, oPcPlus1, oFetchValid, oFlush, oHalted, oBranchCount
    );
endinterface

// File: rtl/fetch_pc_unit_sat_counter.sv
// rtl/fetch_pc_unit_sat_counter.sv - up counter that sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iInc,
    output logic [WIDTH-1:0] oCount
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            count <= '0;
        end else if (iInc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

    assign oCount = count;
endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - program counter with branch redirect, stall, flush pulse and halt
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int                PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEFAULT),
    parameter int                CNT_WIDTH    = 16
) (
    input  logic             iClk,
    input  logic             iRst_n,
    fetch_pc_unit_if.slave   bus
);
    fetch_state_e        state;
    fetch_state_e        stateNext;
    logic [PC_WIDTH-1:0] pcReg;
    logic [PC_WIDTH-1:0] pcNext;
    logic                branchTaken;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= BOOT;
            pcReg <= RESET_VECTOR;
        end else begin
            state <= stateNext;
            pcReg <= pcNext;
        end
    end

    // Branch beats halt beats stall; a redirect is taken even while stalled.
    always_comb begin
        stateNext   = state;
        pcNext      = pcReg;
        branchTaken = 1'b0;
        case (state)
            BOOT: stateNext = RUN;
            RUN: begin
                if (bus.iBranchCmd) begin
                    pcNext      = bus.iBranchTarget;
                    branchTaken = 1'b1;
                    stateNext   = FLUSH;
                end else if (bus.iHalt) begin
                    stateNext = HALT;
                end else if (!bus.iStall && bus.iImemReady) begin
                    pcNext = pcReg + PC_WIDTH'(1);
                end
            end
            FLUSH:   stateNext = RUN;
            HALT:    stateNext = HALT;
            default: stateNext = BOOT;
        endcase
    end

    assign bus.oPc         = pcReg;
    assign bus.oPcPlus1    = pcReg + PC_WIDTH'(1);
    assign bus.oFetchValid = (state == RUN);
    assign bus.oFlush      = (state == FLUSH);
    assign bus.oHalted     = (state == HALT);

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) uBranchCounter (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iInc   (branchTaken),
        .oCount (bus.oBranchCount)
    );
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - scoreboard bench for fetch_pc_unit against a behavioural fetch model
module tb_fetch_pc_unit;
    localparam int PW      = 16;
    localparam int CW      = 2;
    localparam int PC_MOD  = 1 << PW;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic iClk   = 1'b0;
    logic iRst_n = 1'b0;
    always #5 iClk = ~iClk;

    fetch_pc_unit_if #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

    fetch_pc_unit #(
        .PC_WIDTH     (PW),
        .RESET_VECTOR (16'h0000),
        .CNT_WIDTH    (CW)
    ) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (bus)
    );

    typedef struct {
        int pc;
        bit fv;
        bit fl;
        bit ht;
        int cnt;
    } exp_t;

    exp_t expQ[$];
    int   nCompared   = 0;
    int   nMismatched = 0;

    // Behavioural model: what the fetch stage is doing right now
    int mPc;
    int mCnt;
    bit mBoot;
    bit mFlush;
    bit mHalt;

    task automatic chk(input string name, input int act, input int req);
        nCompared++;
        if (act != req) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t observe();
        exp_t e;
        e.pc  = mPc;
        e.fv  = !(mBoot || mFlush || mHalt);
        e.fl  = mFlush;
        e.ht  = mHalt;
        e.cnt = mCnt;
        return e;
    endfunction

    task automatic compareAll(input exp_t e);
        chk("oPc",          int'(bus.oPc),          e.pc);
        chk("oPcPlus1",     int'(bus.oPcPlus1),     (e.pc + 1) % PC_MOD);
        chk("oFetchValid",  int'(bus.oFetchValid),  int'(e.fv));
        chk("oFlush",       int'(bus.oFlush),       int'(e.fl));
        chk("oHalted",      int'(bus.oHalted),      int'(e.ht));
        chk("oBranchCount", int'(bus.oBranchCount), e.cnt);
    endtask

    function automatic void modelReset();
        mPc    = 0;
        mCnt   = 0;
        mBoot  = 1'b1;
        mFlush = 1'b0;
        mHalt  = 1'b0;
    endfunction

    function automatic void modelStep(input bit br, input int tgt, input bit stall,
                                      input bit halt, input bit ready);
        if (mHalt) return;
        if (mBoot) begin
            mBoot = 1'b0;
        end else if (mFlush) begin
            mFlush = 1'b0;
        end else if (br) begin
            mPc    = tgt % PC_MOD;
            mCnt   = (mCnt < CNT_MAX) ? mCnt + 1 : CNT_MAX;
            mFlush = 1'b1;
        end else if (halt) begin
            mHalt = 1'b1;
        end else if (!stall && ready) begin
            mPc = (mPc + 1) % PC_MOD;
        end
    endfunction

    always @(negedge iClk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            compareAll(e);
        end
    end

    task automatic cycle(input bit br, input int tgt, input bit stall, input bit halt, input bit ready);
        bus.iBranchCmd    = br;
        bus.iBranchTarget = tgt[PW-1:0];
        bus.iStall        = stall;
        bus.iHalt         = halt;
        bus.iImemReady    = ready;
        @(posedge iClk);
        #1;
        if (!iRst_n) modelReset();
        else         modelStep(br, tgt, stall, halt, ready);
        expQ.push_back(observe());
    endtask

    task automatic idle();
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    // Asserted mid-cycle so the outputs must change without any clock edge
    task automatic doReset();
        iRst_n = 1'b0;
        #1;
        expQ.delete();
        modelReset();
        compareAll(observe());
        expQ.push_back(observe());
        idle();
        iRst_n = 1'b1;
    endtask

    task automatic runUntilPc(input int target, input int limit);
        for (int i = 0; i < limit && mPc != target; i++) idle();
        if (mPc != target) begin
            nCompared++;
            nMismatched++;
            $display("FAIL reach_pc: stopped at 0x%0h expected 0x%0h", mPc, target);
        end
    endtask

    initial begin
        bus.iBranchCmd    = 1'b0;
        bus.iBranchTarget = '0;
        bus.iStall        = 1'b0;
        bus.iHalt         = 1'b0;
        bus.iImemReady    = 1'b1;
        iRst_n            = 1'b0;
        #1;
        modelReset();
        compareAll(observe());
        idle();
        idle();
        iRst_n = 1'b1;

        // Boot cycle then sequential fetch
        repeat (4) idle();

        // Redirect at 0x0005
        runUntilPc(5, 20);
        cycle(1'b1, 'h40, 1'b0, 1'b0, 1'b1);
        idle();
        idle();

        // Stall at 0x0010, redirect while stalled, memory not ready
        cycle(1'b1, 'h10, 1'b0, 1'b0, 1'b1);
        idle();
        repeat (3) cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 'h100, 1'b1, 1'b0, 1'b0);
        idle();
        repeat (2) cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
        idle();

        // Wrap at the top of the address space
        cycle(1'b1, 'hFFFE, 1'b0, 1'b0, 1'b1);
        repeat (4) idle();

        // Halt at 0x0020 ignores later branches, then reset clears it
        cycle(1'b1, 'h20, 1'b0, 1'b0, 1'b1);
        idle();
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) cycle(i[0], int'($urandom_range(0, PC_MOD - 1)), 1'b0, 1'b0, 1'b1);
        doReset();

        // Saturation with branches held every cycle (flush cycles swallow every other one)
        idle();
        for (int i = 0; i < 10; i++) cycle(1'b1, int'($urandom_range(0, PC_MOD - 1)), 1'b0, 1'b0, 1'b1);

        // Reset landing inside a flush cycle
        cycle(1'b1, 'h1234, 1'b0, 1'b0, 1'b1);
        doReset();
        repeat (3) idle();

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            if (mHalt && ($urandom_range(0, 7) == 0)) begin
                doReset();
            end else if ($urandom_range(0, 99) == 0) begin
                doReset();
            end else begin
                cycle($urandom_range(0, 4) == 0, int'($urandom_range(0, PC_MOD - 1)),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
                      $urandom_range(0, 4) != 0);
            end
        end

        for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge iClk);
        if (expQ.size() > 0) begin
            nCompared++;
            nMismatched++;
            $display("FAIL drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
